// File: rtl/rv_regfile.sv
// rv_regfile: RV32 integer register file, x1..x31 storage, 2 registered read ports, 1 write port.
// Ports: i_clk, i_reset (async high), i_read_en, i_rs1_addr, i_rs2_addr, i_wr_en, i_wr_addr,
//   i_wr_data, o_reg1_data, o_reg2_data, o_ready. Macro REGFILE_BYPASS_EN forwards same-edge writes.
module rv_regfile #(
  parameter logic [31:0] RESET_VALUE    = 32'h0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_read_en,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  input  logic        i_wr_en,
  input  logic [4:0]  i_wr_addr,
  input  logic [31:0] i_wr_data,
  output logic [31:0] o_reg1_data,
  output logic [31:0] o_reg2_data,
  output logic        o_ready
);

  typedef enum logic {CLEAR, READY} state_t;

  localparam state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : READY;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  cnt;
  logic [4:0]  cnt_nxt;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        wr_hit;
  logic        byp1;
  logic        byp2;
  logic [31:0] rd1;
  logic [31:0] rd2;

  logic [31:0] mem [1:31];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= RST_STATE;
      cnt   <= 5'd1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // CLEAR owns the write port; user writes are dropped until READY.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    we        = 1'b0;
    waddr     = i_wr_addr;
    wdata     = i_wr_data;
    o_ready   = 1'b0;
    unique case (state)
      CLEAR: begin
        we      = 1'b1;
        waddr   = cnt;
        wdata   = RESET_VALUE;
        cnt_nxt = cnt + 5'd1;
        if (cnt == 5'd31) state_nxt = READY;
      end
      READY: begin
        o_ready = 1'b1;
        we      = i_wr_en && (i_wr_addr != 5'd0);
      end
      default: ;
    endcase
  end

  // Storage has no reset; only the clear sequence initialises it.
  always_ff @(posedge i_clk) begin
    if (we && (waddr != 5'd0)) mem[waddr] <= wdata;
  end

  assign wr_hit = (state == READY) && i_wr_en && (i_wr_addr != 5'd0);

`ifdef REGFILE_BYPASS_EN
  assign byp1 = wr_hit && (i_wr_addr == i_rs1_addr);
  assign byp2 = wr_hit && (i_wr_addr == i_rs2_addr);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  always_comb begin
    rd1 = 32'h0;
    if (i_rs1_addr == 5'd0) rd1 = 32'h0;
    else if (state == CLEAR) rd1 = RESET_VALUE;
    else if (byp1) rd1 = i_wr_data;
    else rd1 = mem[i_rs1_addr];
  end

  always_comb begin
    rd2 = 32'h0;
    if (i_rs2_addr == 5'd0) rd2 = 32'h0;
    else if (state == CLEAR) rd2 = RESET_VALUE;
    else if (byp2) rd2 = i_wr_data;
    else rd2 = mem[i_rs2_addr];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_reg1_data <= 32'h0;
      o_reg2_data <= 32'h0;
    end else if (i_read_en) begin
      o_reg1_data <= rd1;
      o_reg2_data <= rd2;
    end
  end

endmodule

// File: tb/tb_rv_regfile.sv
// tb_rv_regfile: randomized and directed bench for rv_regfile
// against a register-array reference model.
module tb_rv_regfile;

  localparam logic [31:0] RV = 32'h0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        read_en = 1'b0;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;
  logic        wr_en = 1'b0;
  logic [4:0]  wa = 5'd0;
  logic [31:0] wd = 32'h0;
  logic [31:0] r1;
  logic [31:0] r2;
  logic        rdy;

  int tests = 0;
  int fails = 0;

  // reference model
  bit          m_ready = 1'b0;
  int          m_clr = 0;
  logic [31:0] m_mem [32];
  logic [31:0] m_r1 = 32'h0;
  logic [31:0] m_r2 = 32'h0;

  rv_regfile #(.RESET_VALUE(RV), .CLEAR_ON_RESET(1'b1)) dut (
    .i_clk(clk), .i_reset(rst), .i_read_en(read_en),
    .i_rs1_addr(rs1), .i_rs2_addr(rs2),
    .i_wr_en(wr_en), .i_wr_addr(wa), .i_wr_data(wd),
    .o_reg1_data(r1), .o_reg2_data(r2), .o_ready(rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_rd(logic [4:0] a, bit wv);
    if (a == 5'd0) return 32'h0;
    if (!m_ready) return RV;
    if (BYP && wv && wa == a) return wd;
    return m_mem[a];
  endfunction

  task automatic tick(string tag);
    logic [31:0] n1;
    logic [31:0] n2;
    bit wv;
    n1 = m_r1;
    n2 = m_r2;
    wv = m_ready && wr_en && (wa != 5'd0);
    if (rst) begin
      n1 = 32'h0;
      n2 = 32'h0;
    end else if (read_en) begin
      n1 = m_rd(rs1, wv);
      n2 = m_rd(rs2, wv);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_ready = 1'b0;
      m_clr = 0;
    end else if (!m_ready) begin
      m_clr++;
      if (m_clr == 31) begin
        m_ready = 1'b1;
        for (int i = 1; i < 32; i++) m_mem[i] = RV;
      end
    end else if (wv) begin
      m_mem[wa] = wd;
    end
    m_r1 = n1;
    m_r2 = n2;
    chk({tag, ".r1"}, r1, m_r1);
    chk({tag, ".r2"}, r2, m_r2);
    chk({tag, ".rdy"}, {31'h0, rdy}, {31'h0, m_ready});
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) m_mem[i] = 'x;
    m_mem[0] = 32'h0;

    // async reset before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst.r1", r1, 32'h0);
    chk("rst.r2", r2, 32'h0);
    chk("rst.rdy", {31'h0, rdy}, 32'h0);
    tick("rst");
    rst = 1'b0;

    // clear: writes to x5 are discarded
    read_en = 1'b1;
    rs1 = 5'd5;
    wr_en = 1'b1;
    wa = 5'd5;
    for (int k = 1; k <= 31; k++) begin
      wd = $urandom;
      rs2 = 5'($urandom);
      tick("clear");
      chk("clear.ready_k", {31'h0, rdy}, {31'h0, (k == 31)});
    end
    wr_en = 1'b0;
    rs2 = 5'd0;
    tick("x5");
    chk("x5.zero", r1, 32'h0);

    // write x7, then read x7 / x0
    wr_en = 1'b1; wa = 5'd7; wd = 32'hDEADBEEF;
    tick("w7");
    wr_en = 1'b0; rs1 = 5'd7; rs2 = 5'd0;
    tick("r7");
    chk("r7.d", r1, 32'hDEADBEEF);
    chk("r7.x0", r2, 32'h0);

    // x0 discards writes
    wr_en = 1'b1; wa = 5'd0; wd = 32'h12345678;
    tick("w0");
    wr_en = 1'b0; rs1 = 5'd0;
    tick("r0");
    chk("r0.d", r1, 32'h0);

    // same-edge write/read collision on x3
    wr_en = 1'b1; wa = 5'd3; wd = 32'h0BADF00D;
    tick("w3a");
    wd = 32'hA5A5A5A5; rs1 = 5'd3; rs2 = 5'd3;
    tick("coll");
    chk("coll.r1", r1, BYP ? 32'hA5A5A5A5 : 32'h0BADF00D);
    chk("coll.r2", r2, BYP ? 32'hA5A5A5A5 : 32'h0BADF00D);
    wr_en = 1'b0;
    tick("coll2");
    chk("coll2.r1", r1, 32'hA5A5A5A5);

    // stall holds outputs across a write
    wr_en = 1'b1; wa = 5'd9; wd = 32'h11;
    tick("w9");
    wr_en = 1'b0; rs1 = 5'd9; rs2 = 5'd9;
    tick("r9");
    chk("r9.d", r1, 32'h11);
    read_en = 1'b0;
    wr_en = 1'b1; wd = 32'h22;
    tick("hold1");
    wr_en = 1'b0;
    tick("hold2");
    chk("hold.r1", r1, 32'h11);
    chk("hold.r2", r2, 32'h11);
    read_en = 1'b1;
    tick("unhold");
    chk("unhold.r1", r1, 32'h22);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      read_en = ($urandom_range(0, 4) != 0);
      rs1 = 5'($urandom);
      rs2 = ($urandom_range(0, 5) == 0) ? rs1 : 5'($urandom);
      wr_en = $urandom_range(0, 1) == 1;
      wa = ($urandom_range(0, 3) == 0) ? rs1 : 5'($urandom);
      wd = $urandom;
      tick("rand");
    end

    // reset mid-clear restarts the 31-cycle sequence
    wr_en = 1'b0;
    read_en = 1'b1;
    rs1 = 5'd9; rs2 = 5'd3;
    rst = 1'b1;
    tick("rst2");
    rst = 1'b0;
    for (int k = 0; k < 10; k++) tick("clr10");
    rst = 1'b1;
    #1;
    m_r1 = 32'h0; m_r2 = 32'h0; m_ready = 1'b0; m_clr = 0;
    chk("midrst.r1", r1, 32'h0);
    chk("midrst.r2", r2, 32'h0);
    chk("midrst.rdy", {31'h0, rdy}, 32'h0);
    tick("midrst");
    rst = 1'b0;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      tick("reclr");
      if (rdy) begin
        n = k;
        break;
      end
    end
    chk("reclr.cycles", n, 31);
    tick("after");
    chk("after.x9", r1, RV);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv_regfile.md
RV_REGFILE -- requirements
Module: rv_regfile

Interface
REQ-001 SHALL provide parameter RESET_VALUE, default 32'h0, value loaded into x1..x31 by the clear sequence.
REQ-002 SHALL provide parameter CLEAR_ON_RESET, default 1'b1: 1 runs the clear sequence after reset, 0 skips it.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_reset  input  1  asynchronous, active-high reset.
REQ-005 i_read_en  input  1  capture new read addresses; low holds both read outputs (pipeline stall).
REQ-006 i_rs1_addr  input  5  read port 1 address, sampled with decode-stage timing.
REQ-007 i_rs2_addr  input  5  read port 2 address.
REQ-008 i_wr_en  input  1  write-back strobe.
REQ-009 i_wr_addr  input  5  write-back destination register.
REQ-010 i_wr_data  input  32  write-back data.
REQ-011 o_reg1_data  output  32  registered read data, port 1; feeds the ALU1 stage's reg1 input.
REQ-012 o_reg2_data  output  32  registered read data, port 2.
REQ-013 o_ready  output  1  high once the clear sequence is complete and writes are accepted.

Function
REQ-014 Storage SHALL be 31 x 32-bit entries for x1..x31; x0 SHALL have no storage.
REQ-015 Read latency SHALL be exactly one cycle: addresses sampled at edge N with i_read_en=1 appear on o_regN_data after edge N.
REQ-016 With i_read_en=0, o_reg1_data and o_reg2_data SHALL hold their previous values, including across writes to the held register.
REQ-017 A read of address 0 SHALL return 32'h0 regardless of any write to address 0.
REQ-018 A write with i_wr_en=1, o_ready=1 and i_wr_addr!=0 SHALL update the entry at the clock edge.
REQ-019 Writes to address 0 SHALL be discarded.
REQ-020 Writes with o_ready=0 SHALL be discarded.
REQ-021 The FSM SHALL have two states: CLEAR and READY.
REQ-022 In CLEAR, a 5-bit counter starting at 1 SHALL write RESET_VALUE to entry counter each cycle.
REQ-023 CLEAR SHALL go to READY on the cycle counter==31 is written; CLEAR lasts exactly 31 cycles.
REQ-024 In CLEAR, o_ready=0 and read outputs SHALL load RESET_VALUE, or 0 for address 0, when i_read_en=1.
REQ-025 READY SHALL be terminal until the next reset.
REQ-026 With CLEAR_ON_RESET=0, the FSM SHALL enter READY directly from reset; storage contents are then undefined until written.
REQ-027 Both read ports addressing the same register SHALL return identical data.

Reset
REQ-028 On i_reset high: o_reg1_data=0, o_reg2_data=0, counter=1, state=CLEAR (READY if CLEAR_ON_RESET=0), o_ready=0 (1 if CLEAR_ON_RESET=0).
REQ-029 Reset asserted mid-CLEAR SHALL restart the sequence from counter=1 after deassertion.
REQ-030 Storage entries SHALL NOT be reset asynchronously; only the clear sequence initialises them.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN defined: a read port sampling address A (A!=0) while a valid write to A occurs on the same edge SHALL return i_wr_data; applies independently to each port.
REQ-032 REGFILE_BYPASS_EN undefined: the same collision SHALL return the pre-write contents; the new value is visible on the next read.

Verification
REQ-033 Reset, then 31 cycles with i_wr_en=1 -> o_ready rises after cycle 31; the writes are discarded; read of x5 returns 0.
REQ-034 READY: write x7=32'hDEADBEEF, next cycle read rs1=7, rs2=0 -> o_reg1_data=32'hDEADBEEF, o_reg2_data=0.
REQ-035 Write x0=32'h12345678, then read rs1=0 -> o_reg1_data=0.
REQ-036 Same edge: write x3=32'hA5A5A5A5 and read rs1=3, rs2=3 -> both outputs 32'hA5A5A5A5 with REGFILE_BYPASS_EN; old value without it.
REQ-037 Read x9 (value 32'h11), drop i_read_en, write x9=32'h22 -> outputs stay 32'h11; raise i_read_en -> 32'h22 next cycle.
REQ-038 Assert i_reset at clear cycle 10 -> o_ready=0 and outputs 0 immediately; after release o_ready rises exactly 31 cycles later.
